// File: rtl/spi_memory_responder.sv
// spi_memory_responder
//
// SPI (mode 0) target that fronts a 2**ADDR_BITS x 16-bit word array.
// The SPI pins are asynchronous to clk; they are brought into the clk
// domain through 2-flop synchronisers and all protocol decoding is done
// on the synchronised copies.
//
// Commands (first byte after cs falls, MSB first):
//   0x06 WREN  : set the write-enable latch
//   0x03 READ  : 16-bit address, then stream words out until cs rises
//   0x42 WRITE : 16-bit address, then stream words in (committed if wel=1)
//   0x3C STORE : pulse store_pulse
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   cs           SPI chip select, active low (async)
//   sck          SPI clock, mode 0 (async)
//   mosi         serial data in, MSB first (async)
//   miso         serial read data out, MSB first
//   wel          write-enable latch status
//   write_strobe one-clk pulse when a word has been committed
//   write_addr   word address of the last committed write
//   write_data   data of the last committed write
//   store_pulse  one-clk pulse when a STORE command completes
//   bad_opcode   one-clk pulse when an opcode is not recognised
module spi_memory_responder #(
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        sck,
    input  logic        mosi,
    output logic        miso,
    output logic        wel,
    output logic        write_strobe,
    output logic [15:0] write_addr,
    output logic [15:0] write_data,
    output logic        store_pulse,
    output logic        bad_opcode
);

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h42;
    localparam logic [7:0] OP_STORE = 8'h3C;

    typedef enum logic [2:0] {
        IDLE,
        OPCODE,
        ADDR,
        RDATA,
        WDATA,
        IGNORE
    } state_t;

    state_t state, state_next;

    // synchroniser stages; _p2 holds the previous synchronised value
    logic cs_p0, cs_p1, cs_p2;
    logic sck_p0, sck_p1, sck_p2;
    logic mosi_p0, mosi_p1;

    // After reset the synchronisers start at their idle values, so a cs that
    // was already low would look like a fresh fall. armed only rises once a
    // real (post-reset) cs-high sample has reached cs_p1.
    logic live_p0, live_p1, armed;

    logic                 cs_rise, cs_fall, sck_rise, sck_fall;
    logic [4:0]           bit_cnt, bit_cnt_next;
    logic [14:0]          in_shift, in_shift_next;
    logic [15:0]          shifted;
    logic [15:0]          rd_shift, rd_shift_next;
    logic [ADDR_BITS-1:0] word_addr, word_addr_next, addr_inc;
    logic                 wr_cmd, wr_cmd_next;
    logic                 wel_next;
    logic                 miso_next;
    logic                 commit;
    logic                 store_next, bad_next;

    logic [15:0] mem [DEPTH];

    assign cs_fall  = cs_p2 & ~cs_p1;
    assign cs_rise  = ~cs_p2 & cs_p1;
    assign sck_rise = ~sck_p2 & sck_p1;
    assign sck_fall = sck_p2 & ~sck_p1;

    // mosi_p1 has the same latency as sck_p1, so it is the bit being clocked
    assign shifted  = {in_shift, mosi_p1};
    assign addr_inc = word_addr + 1'b1;

    // ---- decode stage: next-state and output logic ----
    always_comb begin
        state_next     = state;
        bit_cnt_next   = bit_cnt;
        in_shift_next  = in_shift;
        rd_shift_next  = rd_shift;
        word_addr_next = word_addr;
        wr_cmd_next    = wr_cmd;
        wel_next       = wel;
        miso_next      = (state == RDATA) ? miso : 1'b0;
        commit         = 1'b0;
        store_next     = 1'b0;
        bad_next       = 1'b0;

        if (cs_rise) begin
            // end of transaction wins over any sck edge seen in the same clk
            state_next    = IDLE;
            bit_cnt_next  = '0;
            in_shift_next = '0;
            rd_shift_next = '0;
            miso_next     = 1'b0;
            wr_cmd_next   = 1'b0;
            if (wr_cmd) begin
                wel_next = 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall && armed) begin
                        state_next    = OPCODE;
                        bit_cnt_next  = '0;
                        in_shift_next = '0;
                    end
                end

                OPCODE: begin
                    if (sck_rise) begin
                        in_shift_next = shifted[14:0];
                        bit_cnt_next  = bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt_next  = '0;
                            in_shift_next = '0;
                            case (shifted[7:0])
                                OP_WREN: begin
                                    wel_next   = 1'b1;
                                    state_next = IGNORE;
                                end
                                OP_STORE: begin
                                    store_next = 1'b1;
                                    state_next = IGNORE;
                                end
                                OP_READ: begin
                                    state_next = ADDR;
                                end
                                OP_WRITE: begin
                                    wr_cmd_next = 1'b1;
                                    state_next  = ADDR;
                                end
                                default: begin
                                    bad_next   = 1'b1;
                                    state_next = IGNORE;
                                end
                            endcase
                        end
                    end
                end

                ADDR: begin
                    if (sck_rise) begin
                        in_shift_next = shifted[14:0];
                        bit_cnt_next  = bit_cnt + 5'd1;
                        if (bit_cnt == 5'd15) begin
                            // upper address bits beyond the array are dropped
                            word_addr_next = shifted[ADDR_BITS-1:0];
                            bit_cnt_next   = '0;
                            in_shift_next  = '0;
                            if (wr_cmd) begin
                                state_next = WDATA;
                            end else begin
                                rd_shift_next = mem[shifted[ADDR_BITS-1:0]];
                                state_next    = RDATA;
                            end
                        end
                    end
                end

                RDATA: begin
                    if (sck_fall) begin
                        miso_next     = rd_shift[15];
                        rd_shift_next = {rd_shift[14:0], 1'b0};
                        bit_cnt_next  = bit_cnt + 5'd1;
                        if (bit_cnt == 5'd15) begin
                            // last bit of this word is on miso; prefetch the next
                            bit_cnt_next   = '0;
                            word_addr_next = addr_inc;
                            rd_shift_next  = mem[addr_inc];
                        end
                    end
                end

                WDATA: begin
                    if (sck_rise) begin
                        in_shift_next = shifted[14:0];
                        bit_cnt_next  = bit_cnt + 5'd1;
                        if (bit_cnt == 5'd15) begin
                            bit_cnt_next  = '0;
                            in_shift_next = '0;
                            if (wel) begin
                                commit         = 1'b1;
                                word_addr_next = addr_inc;
                            end
                        end
                    end
                end

                IGNORE: begin
                    state_next = IGNORE;
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // ---- register stage ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_p0        <= 1'b1;
            cs_p1        <= 1'b1;
            cs_p2        <= 1'b1;
            sck_p0       <= 1'b0;
            sck_p1       <= 1'b0;
            sck_p2       <= 1'b0;
            mosi_p0      <= 1'b0;
            mosi_p1      <= 1'b0;
            live_p0      <= 1'b0;
            live_p1      <= 1'b0;
            armed        <= 1'b0;
            state        <= IDLE;
            bit_cnt      <= '0;
            in_shift     <= '0;
            rd_shift     <= '0;
            word_addr    <= '0;
            wr_cmd       <= 1'b0;
            wel          <= 1'b0;
            miso         <= 1'b0;
            write_strobe <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            store_pulse  <= 1'b0;
            bad_opcode   <= 1'b0;
        end else begin
            cs_p0        <= cs;
            cs_p1        <= cs_p0;
            cs_p2        <= cs_p1;
            sck_p0       <= sck;
            sck_p1       <= sck_p0;
            sck_p2       <= sck_p1;
            mosi_p0      <= mosi;
            mosi_p1      <= mosi_p0;
            live_p0      <= 1'b1;
            live_p1      <= live_p0;
            if (live_p1 && cs_p1) begin
                armed <= 1'b1;
            end
            state        <= state_next;
            bit_cnt      <= bit_cnt_next;
            in_shift     <= in_shift_next;
            rd_shift     <= rd_shift_next;
            word_addr    <= word_addr_next;
            wr_cmd       <= wr_cmd_next;
            wel          <= wel_next;
            miso         <= miso_next;
            store_pulse  <= store_next;
            bad_opcode   <= bad_next;
            // strobe lands together with the updated write_addr/write_data
            write_strobe <= commit;
            if (commit) begin
                write_addr <= 16'(word_addr);
                write_data <= shifted;
            end
        end
    end

    // array has no reset so its contents survive a reset pulse
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[word_addr] <= shifted;
        end
    end

endmodule

// File: tb/tb_spi_memory_responder.sv
// Scoreboarded bench for spi_memory_responder: a behavioural model (word
// array + write-enable flag) predicts write commits, read words and pulses;
// a monitor process compares them as the DUT produces them.
module tb_spi_memory_responder;

    localparam int HALF = 5;   // clk cycles per sck phase

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs = 1'b1;
    logic        sck = 1'b0;
    logic        mosi = 1'b0;
    logic        miso, wel, write_strobe, store_pulse, bad_opcode;
    logic [15:0] write_addr, write_data;

    spi_memory_responder #(.ADDR_BITS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .cs           (cs),
        .sck          (sck),
        .mosi         (mosi),
        .miso         (miso),
        .wel          (wel),
        .write_strobe (write_strobe),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .store_pulse  (store_pulse),
        .bad_opcode   (bad_opcode)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // behavioural model
    logic [15:0] ref_mem [256];
    logic        ref_wel = 1'b0;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [15:0] obs_rd[$];
    int          obs_quiet[$];
    int          exp_store = 0;
    int          exp_bad = 0;
    logic [15:0] wbuf[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sel();
        cs = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic desel();
        sck = 1'b0;
        wait_clk(HALF);
        cs = 1'b1;
        wait_clk(HALF + 2);
    endtask

    // one mode-0 bit: drive mosi in the low phase, sample miso, rise, fall
    task automatic xbit(input logic b, output logic m);
        mosi = b;
        wait_clk(HALF);
        m = miso;
        sck = 1'b1;
        wait_clk(HALF);
        sck = 1'b0;
    endtask

    task automatic shift_word(input logic [15:0] v, input int n, output logic [15:0] got);
        logic m;
        got = '0;
        for (int i = n - 1; i >= 0; i--) begin
            xbit(v[i], m);
            got = {got[14:0], m};
        end
    endtask

    // opcode-only style transaction (WREN / STORE / unknown) plus trailing bits
    task automatic txn_simple(input logic [7:0] op, input int extra);
        logic [15:0] g;
        int ones;
        ones = 0;
        if (op == 8'h06)      ref_wel = 1'b1;
        else if (op == 8'h3C) exp_store++;
        else                  exp_bad++;
        sel();
        shift_word({8'h00, op}, 8, g);
        ones += $countones(g);
        for (int k = 0; k < extra; k += 16) begin
            shift_word(16'($urandom), (extra - k > 16) ? 16 : extra - k, g);
            ones += $countones(g);
        end
        obs_quiet.push_back(ones);
        desel();
        check("wel_after_simple", 32'(wel), 32'(ref_wel));
        check("miso_after_simple", 32'(miso), 32'd0);
    endtask

    // WRITE of the words in wbuf, then 'partial' leftover bits before cs rises
    task automatic do_write(input logic [15:0] a, input int partial);
        logic [15:0] g;
        logic [7:0]  idx;
        int ones;
        ones = 0;
        idx = a[7:0];
        foreach (wbuf[i]) begin
            if (ref_wel) begin
                ref_mem[idx] = wbuf[i];
                exp_wr.push_back('{addr: {8'h00, idx}, data: wbuf[i]});
            end
            idx = idx + 8'd1;
        end
        ref_wel = 1'b0;
        sel();
        shift_word(16'h0042, 8, g);
        ones += $countones(g);
        shift_word(a, 16, g);
        ones += $countones(g);
        foreach (wbuf[i]) begin
            shift_word(wbuf[i], 16, g);
            ones += $countones(g);
        end
        if (partial > 0) begin
            shift_word(16'($urandom), partial, g);
            ones += $countones(g);
        end
        obs_quiet.push_back(ones);
        desel();
        check("wel_after_write", 32'(wel), 32'(ref_wel));
        check("miso_after_write", 32'(miso), 32'd0);
    endtask

    task automatic do_read(input logic [15:0] a, input int n);
        logic [15:0] g;
        logic [7:0]  idx;
        int ones;
        ones = 0;
        idx = a[7:0];
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(ref_mem[idx]);
            idx = idx + 8'd1;
        end
        sel();
        shift_word(16'h0003, 8, g);
        ones += $countones(g);
        shift_word(a, 16, g);
        ones += $countones(g);
        obs_quiet.push_back(ones);
        for (int i = 0; i < n; i++) begin
            shift_word(16'($urandom), 16, g);
            obs_rd.push_back(g);
        end
        desel();
        check("miso_after_read", 32'(miso), 32'd0);
    endtask

    // monitor: compares DUT outputs against the expected queues
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (write_strobe) begin
                check("write_strobe_expected", 32'(exp_wr.size() > 0), 32'd1);
                if (exp_wr.size() > 0) begin
                    e = exp_wr.pop_front();
                    check("write_addr", 32'(write_addr), 32'(e.addr));
                    check("write_data", 32'(write_data), 32'(e.data));
                end
            end
            if (store_pulse) begin
                check("store_pulse_expected", 32'(exp_store > 0), 32'd1);
                if (exp_store > 0) exp_store--;
            end
            if (bad_opcode) begin
                check("bad_opcode_expected", 32'(exp_bad > 0), 32'd1);
                if (exp_bad > 0) exp_bad--;
            end
            while (obs_rd.size() > 0) begin
                check("read_pending", 32'(exp_rd.size() > 0), 32'd1);
                if (exp_rd.size() > 0) check("read_word", 32'(obs_rd.pop_front()), 32'(exp_rd.pop_front()));
                else void'(obs_rd.pop_front());
            end
            while (obs_quiet.size() > 0) begin
                check("miso_quiet_ones", 32'(obs_quiet.pop_front()), 32'd0);
            end
        end
    end

    initial begin
        logic [15:0] g;
        logic [15:0] a;
        logic [7:0]  op;
        int          kind;

        // reset state
        wait_clk(3);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_wel", 32'(wel), 32'd0);
        check("rst_write_strobe", 32'(write_strobe), 32'd0);
        check("rst_write_addr", 32'(write_addr), 32'd0);
        check("rst_write_data", 32'(write_data), 32'd0);
        check("rst_store_pulse", 32'(store_pulse), 32'd0);
        check("rst_bad_opcode", 32'(bad_opcode), 32'd0);
        reset = 1'b1;
        wait_clk(6);

        // prefill words 0x00..0x0F and 0x20
        txn_simple(8'h06, 0);
        wbuf.delete();
        for (int i = 0; i < 16; i++) wbuf.push_back(16'($urandom));
        do_write(16'h0000, 0);
        txn_simple(8'h06, 0);
        wbuf.delete();
        wbuf.push_back(16'h7777);
        do_write(16'h0020, 0);

        // write then read back
        txn_simple(8'h06, 0);
        wbuf.delete();
        wbuf.push_back(16'hBEEF);
        do_write(16'h0010, 0);
        do_read(16'h0010, 1);

        // write without WREN is discarded
        wbuf.delete();
        wbuf.push_back(16'h1234);
        do_write(16'h0020, 0);
        do_read(16'h0020, 1);

        // burst write wrapping past the top of the array, burst read across it
        txn_simple(8'h06, 0);
        wbuf.delete();
        wbuf.push_back(16'hAAAA);
        wbuf.push_back(16'h5555);
        do_write(16'h00FF, 0);
        do_read(16'h00FF, 2);

        // STORE and an unknown opcode with trailing bits
        txn_simple(8'h3C, 8);
        txn_simple(8'hFF, 24);

        // write aborted after 10 data bits
        txn_simple(8'h06, 0);
        wbuf.delete();
        do_write(16'h0005, 10);
        do_read(16'h0005, 1);

        // reset in the middle of a read
        txn_simple(8'h06, 0);
        sel();
        shift_word(16'h0003, 8, g);
        shift_word(16'h0010, 16, g);
        shift_word(16'h0000, 5, g);
        check("partial_read_bits", 32'(g), 32'(ref_mem[8'h10] >> 11));
        reset = 1'b0;
        ref_wel = 1'b0;
        #1;
        check("midreset_miso", 32'(miso), 32'd0);
        check("midreset_wel", 32'(wel), 32'd0);
        check("midreset_write_addr", 32'(write_addr), 32'd0);
        wait_clk(3);
        reset = 1'b1;
        wait_clk(4);
        // cs never went high since reset: a WREN here must be ignored
        shift_word(16'h0006, 8, g);
        desel();
        check("no_txn_without_fresh_cs_fall", 32'(wel), 32'(ref_wel));
        do_read(16'h0010, 1);

        // randomized traffic on words 0x00..0x0F (upper address bits random)
        for (int t = 0; t < 30; t++) begin
            kind = $urandom_range(0, 5);
            a = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 12))};
            case (kind)
                0, 5: txn_simple(8'h06, $urandom_range(0, 4));
                1: begin
                    wbuf.delete();
                    for (int i = 0; i < $urandom_range(0, 3); i++) wbuf.push_back(16'($urandom));
                    do_write(a, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 15) : 0);
                end
                2: do_read(a, $urandom_range(1, 3));
                3: txn_simple(8'h3C, $urandom_range(0, 4));
                default: begin
                    do op = 8'($urandom);
                    while (op == 8'h06 || op == 8'h03 || op == 8'h42 || op == 8'h3C);
                    txn_simple(op, $urandom_range(0, 20));
                end
            endcase
        end

        wait_clk(20);
        check("pending_write_strobes", 32'(exp_wr.size()), 32'd0);
        check("pending_reads", 32'(exp_rd.size()), 32'd0);
        check("pending_store_pulses", 32'(exp_store), 32'd0);
        check("pending_bad_opcodes", 32'(exp_bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
